// File: rtl/sdr_cmd_phy.sv
// SDR SDRAM command/data PHY: registers one accepted command onto the pins, enforces
// per-command gaps, and returns read data. Optional SDR_RD_REG_EN adds a dq input register.
module sdr_cmd_phy #(
    parameter int ADDR_BITS = 13,
    parameter int BA_BITS   = 2,
    parameter int DQ_BITS   = 16,
    parameter int DM_BITS   = DQ_BITS / 8,
    parameter int CAS_LAT   = 3,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int T_WR      = 2,
    parameter int T_MRD     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [BA_BITS-1:0]   cmd_ba,
    input  logic [DQ_BITS-1:0]   cmd_wdata,
    input  logic [DM_BITS-1:0]   cmd_wmask,
    output logic                 rd_valid,
    output logic [DQ_BITS-1:0]   rd_data,
    output logic                 sdr_cke,
    output logic                 sdr_cs_n,
    output logic                 sdr_ras_n,
    output logic                 sdr_cas_n,
    output logic                 sdr_we_n,
    output logic [ADDR_BITS-1:0] sdr_addr,
    output logic [BA_BITS-1:0]   sdr_ba,
    output logic [DM_BITS-1:0]   sdr_dqm,
    output logic [DQ_BITS-1:0]   sdr_dq_o,
    output logic                 sdr_dq_oe,
    input  logic [DQ_BITS-1:0]   sdr_dq_i
);
    localparam logic [2:0] OP_ACT   = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_PRE   = 3'd4;
    localparam logic [2:0] OP_REF   = 3'd5;
    localparam logic [2:0] OP_MRS   = 3'd6;

    typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             gap_cnt_q;
    logic                   accept;
    logic                   rd_busy;
    logic                   pipe_busy;
    logic                   cap_vld;
    logic [DQ_BITS-1:0]     cap_data;
    logic                   vld_p0;
    logic [CAS_LAT-1:0]     vld_sh_p1;

    function automatic logic [3:0] pin_code(input logic [2:0] op);
        case (op)
            OP_ACT:   pin_code = 4'b0011;
            OP_READ:  pin_code = 4'b0101;
            OP_WRITE: pin_code = 4'b0100;
            OP_PRE:   pin_code = 4'b0010;
            OP_REF:   pin_code = 4'b0001;
            OP_MRS:   pin_code = 4'b0000;
            default:  pin_code = 4'b0111;
        endcase
    endfunction

    function automatic logic [7:0] gap_of(input logic [2:0] op);
        case (op)
            OP_ACT:   gap_of = 8'(T_RCD - 1);
            OP_WRITE: gap_of = 8'(T_WR - 1);
            OP_PRE:   gap_of = 8'(T_RP - 1);
            OP_REF:   gap_of = 8'(T_RFC - 1);
            OP_MRS:   gap_of = 8'(T_MRD - 1);
            default:  gap_of = 8'd0;
        endcase
    endfunction

    // WRITE is held off while read data may still be returning on the shared dq bus
    assign cmd_ready = (state_q == ST_IDLE) && !((cmd_op == OP_WRITE) && rd_busy);
    assign accept    = cmd_valid && cmd_ready;
    assign rd_busy   = vld_p0 || (|vld_sh_p1) || pipe_busy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: if (sdr_cke) state_d = ST_IDLE;
            ST_IDLE:  if (accept && (gap_of(cmd_op) != 8'd0)) state_d = ST_WAIT;
            ST_WAIT:  if (gap_cnt_q == 8'd1) state_d = ST_IDLE;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (accept)
                gap_cnt_q <= gap_of(cmd_op);
            else if (gap_cnt_q != 8'd0)
                gap_cnt_q <= gap_cnt_q - 8'd1;
        end
    end

    // Pin stage: command is visible for exactly the cycle after the handshake edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sdr_cke   <= 1'b0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b1111;
            sdr_addr  <= '0;
            sdr_ba    <= '0;
            sdr_dqm   <= '1;
            sdr_dq_o  <= '0;
            sdr_dq_oe <= 1'b0;
            vld_p0    <= 1'b0;
        end else begin
            sdr_cke <= 1'b1;
            vld_p0  <= accept && (cmd_op == OP_READ);
            if (accept) begin
                {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= pin_code(cmd_op);
                sdr_addr  <= cmd_addr;
                sdr_ba    <= cmd_ba;
                sdr_dq_oe <= (cmd_op == OP_WRITE);
                if (cmd_op == OP_WRITE) begin
                    sdr_dqm  <= ~cmd_wmask;
                    sdr_dq_o <= cmd_wdata;
                end else if (cmd_op == OP_READ) begin
                    sdr_dqm <= '0;
                end else begin
                    sdr_dqm <= '1;
                end
            end else begin
                {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b0111;
                sdr_dqm   <= '1;
                sdr_dq_oe <= 1'b0;
            end
        end
    end

    // CAS latency tracking: bit CAS_LAT-1 marks the edge where read data is on dq
    always_ff @(posedge clk) begin
        if (!rst_n)
            vld_sh_p1 <= '0;
        else
            vld_sh_p1 <= {vld_sh_p1[CAS_LAT-2:0], vld_p0};
    end

`ifdef SDR_RD_REG_EN
    logic               vld_p2, vld_p3;
    logic [DQ_BITS-1:0] dq_p2, dq_p3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            dq_p2  <= '0;
            dq_p3  <= '0;
        end else begin
            vld_p2 <= vld_sh_p1[CAS_LAT-1];
            vld_p3 <= vld_p2;
            dq_p2  <= sdr_dq_i;
            dq_p3  <= dq_p2;
        end
    end

    assign cap_vld   = vld_p3;
    assign cap_data  = dq_p3;
    assign pipe_busy = vld_p2 || vld_p3;
`else
    logic               vld_p2;
    logic [DQ_BITS-1:0] dq_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            dq_p2  <= '0;
        end else begin
            vld_p2 <= vld_sh_p1[CAS_LAT-1];
            dq_p2  <= sdr_dq_i;
        end
    end

    assign cap_vld   = vld_p2;
    assign cap_data  = dq_p2;
    assign pipe_busy = vld_p2;
`endif

    // Read return stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= cap_vld;
            if (cap_vld)
                rd_data <= cap_data;
        end
    end
endmodule

// File: doc/sdr_cmd_phy.md
SDR_CMD_PHY -- requirements
Module: sdr_cmd_phy

Interface
REQ-001 Parameters (name, default, meaning): ADDR_BITS, 13, row/column address width; BA_BITS, 2, bank address width; DQ_BITS, 16, data width (multiple of 8); DM_BITS, DQ_BITS/8, byte mask width; CAS_LAT, 3, CAS latency in cycles (2 or 3 only); T_RCD, 2; T_RP, 2; T_RFC, 7; T_WR, 2; T_MRD, 2 (timing gaps in cycles, each >= 1).
REQ-002 Ports (name direction width meaning): clk input 1 clock; rst_n input 1 reset, synchronous active-low.
REQ-003 cmd_valid input 1 command request; cmd_ready output 1 command accept; cmd_op input 3 opcode; cmd_addr input ADDR_BITS address; cmd_ba input BA_BITS bank; cmd_wdata input DQ_BITS write data; cmd_wmask input DM_BITS byte enables (1 = write byte).
REQ-004 rd_valid output 1 read-data strobe; rd_data output DQ_BITS read data.
REQ-005 sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n output 1 each, SDRAM control pins; sdr_addr output ADDR_BITS; sdr_ba output BA_BITS; sdr_dqm output DM_BITS; sdr_dq_o output DQ_BITS; sdr_dq_oe output 1 dq tristate enable; sdr_dq_i input DQ_BITS.

Function
REQ-006 Opcodes: 0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 REF, 6 MRS; 7 treated as NOP.
REQ-007 Pin encoding {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001, MRS 0000.
REQ-008 Handshake at rising clk when cmd_valid && cmd_ready; all pin outputs registered: accepted command appears on pins for exactly the one cycle after the handshake edge, with sdr_addr=cmd_addr, sdr_ba=cmd_ba.
REQ-009 Cycles with no accepted command drive NOP (0111), sdr_addr/sdr_ba hold last values, sdr_dqm all ones, sdr_dq_oe=0.
REQ-010 Gap counter: on accept, loaded with G-1, G = T_RCD (ACT), T_RP (PRE), T_RFC (REF), T_MRD (MRS), T_WR (WRITE), 1 (READ, NOP); decrements to 0 and holds.
REQ-011 States: RESET (rst_n low), IDLE (counter 0), WAIT (counter > 0); cmd_ready=1 only in IDLE, except WRITE is also blocked while any read is in flight (bus-turnaround guard).
REQ-012 WRITE: during the pin cycle sdr_dq_oe=1, sdr_dq_o=cmd_wdata, sdr_dqm=~cmd_wmask; all other cycles sdr_dq_oe=0.
REQ-013 READ: sdr_dq_i sampled at the end of the pin cycle + CAS_LAT cycles; rd_valid high for one cycle, CAS_LAT+2 cycles after the handshake edge, with that sample on rd_data; sdr_dqm=0 for the READ pin cycle.
REQ-014 Back-to-back READs, one per cycle, are accepted; read tracking is a CAS_LAT-deep shift register; each READ yields exactly one rd_valid, in order.
REQ-015 rd_data holds last value when rd_valid=0.

Reset
REQ-016 While rst_n low at clk edge: sdr_cke=0, cs_n/ras_n/cas_n/we_n=1, sdr_addr=0, sdr_ba=0, sdr_dqm all ones, sdr_dq_o=0, sdr_dq_oe=0, cmd_ready=0, rd_valid=0, rd_data=0, counter=0, read pipeline cleared.
REQ-017 First edge with rst_n high: sdr_cke=1; cmd_ready=1 from the following cycle.
REQ-018 Reset mid-operation aborts all pending gaps and in-flight reads; no rd_valid is produced for reads issued before reset.

Configuration
REQ-019 Macro SDR_RD_REG_EN: defined -> extra input register on sdr_dq_i, rd_valid latency CAS_LAT+3 and WRITE-block window one cycle longer; undefined -> latency CAS_LAT+2 as in REQ-013.

Verification
REQ-020 Reset release: rst_n low 5 cycles, then high -> cke 0 then 1 one edge after release, cmd_ready 1 next cycle, pins 0111, dqm 0x3.
REQ-021 ACT ba=1 addr=0x123 then READ addr=0x010 offered back-to-back, T_RCD=2 -> READ held off 1 cycle; pins 0011 then 0101; rd_valid 5 cycles after READ handshake (CAS_LAT=3) with data = sdr_dq_i model value 0xBEEF.
REQ-022 WRITE wdata=0xA55A wmask=2'b01 -> one pin cycle 0100, dq_oe=1, dq_o=0xA55A, dqm=2'b10; next accept no earlier than 2 cycles later.
REQ-023 Four back-to-back READs then WRITE -> four consecutive rd_valid in order; WRITE ready only after last read leaves the pipeline.
REQ-024 REF (T_RFC=7) then PRE -> cmd_ready low 6 cycles; rst_n pulsed during an in-flight READ -> no rd_valid, all outputs at REQ-016 values.
REQ-025 SDR_RD_REG_EN defined, CAS_LAT=2 -> rd_valid 5 cycles after READ handshake; opcode 7 -> pins 0111, gap 1.
